// File: rtl/pc_gen_if.sv
// Fetch-side handshake between the PC generator and the instruction-fetch unit.
interface pc_gen_if #(
    parameter int unsigned CPU_WIDTH = 64
);
    logic                 if_ready;
    logic                 pc_valid;
    logic [CPU_WIDTH-1:0] pc;

    // PC generator side: offers pc, fetch answers with if_ready
    modport master (
        input  if_ready,
        output pc_valid,
        output pc
    );

    // Fetch unit side
    modport slave (
        output if_ready,
        input  pc_valid,
        input  pc
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: owns the fetch PC, resolves EX-stage branches,
// jumps, traps and mret, and flags misaligned control-transfer targets.
module pc_gen #(
    parameter int unsigned          CPU_WIDTH   = 64,
    parameter logic [CPU_WIDTH-1:0] RESET_PC    = 64'h8000_0000,
    parameter int unsigned          IALIGN_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    pc_gen_if.master             fetch,
    input  logic                 br_valid,
    input  logic [2:0]           br_type,
    input  logic                 jump,
    input  logic                 jalr,
    input  logic [CPU_WIDTH-1:0] ex_pc,
    input  logic [CPU_WIDTH-1:0] imm,
    input  logic [CPU_WIDTH-1:0] rs1,
    input  logic [CPU_WIDTH-1:0] rs2,
    input  logic                 trap,
    input  logic [CPU_WIDTH-1:0] trap_vec,
    input  logic                 mret,
    input  logic [CPU_WIDTH-1:0] epc,
    output logic                 redirect,
    output logic                 misalign,
    output logic [CPU_WIDTH-1:0] misalign_addr
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t               state;
    logic [CPU_WIDTH-1:0] pc_q;
    logic                 pc_valid_q;
    logic                 redirect_q;
    logic                 misalign_q;
    logic [CPU_WIDTH-1:0] misalign_addr_q;

    logic                 br_cond;
    logic                 taken;
    logic                 aligned;
    logic [CPU_WIDTH-1:0] br_target;
    logic [CPU_WIDTH-1:0] jalr_sum;
    logic [CPU_WIDTH-1:0] target;

    // Branch condition and control-transfer target from EX operands
    always_comb begin
        br_cond = 1'b0;
        unique case (br_type)
            3'b001:  br_cond = (rs1 == rs2);
            3'b010:  br_cond = (rs1 != rs2);
            3'b011:  br_cond = ($signed(rs1) <  $signed(rs2));
            3'b100:  br_cond = ($signed(rs1) >= $signed(rs2));
            3'b101:  br_cond = (rs1 <  rs2);
            3'b110:  br_cond = (rs1 >= rs2);
            default: br_cond = 1'b0;
        endcase
        br_target = ex_pc + imm;
        jalr_sum  = (rs1 + imm) & ~CPU_WIDTH'(1);
        target    = (jump && jalr) ? jalr_sum : br_target;
        // jump overrides br_type; everything is qualified by br_valid
        taken     = br_valid && (jump || br_cond);
        aligned   = (target[IALIGN_BITS-1:0] == '0);
    end

    // State machine, PC register and registered event pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= BOOT;
            pc_q            <= RESET_PC;
            pc_valid_q      <= 1'b0;
            redirect_q      <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else if (!ena) begin
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
            unique case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    if (trap) begin
                        pc_q       <= trap_vec;
                        redirect_q <= 1'b1;
                    end else if (mret) begin
                        pc_q       <= epc;
                        redirect_q <= 1'b1;
                    end else if (taken && aligned) begin
                        pc_q       <= target;
                        redirect_q <= 1'b1;
                    end else if (taken) begin
                        misalign_q      <= 1'b1;
                        misalign_addr_q <= target;
                        state           <= HALT;
                        pc_valid_q      <= 1'b0;
                    end else if (fetch.if_ready) begin
                        pc_q <= pc_q + CPU_WIDTH'(4);
                    end
                end
                HALT: begin
                    if (trap) begin
                        pc_q       <= trap_vec;
                        redirect_q <= 1'b1;
                        state      <= RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= BOOT;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Pulses are also masked combinationally so ena=0 forces them low at once
    assign fetch.pc       = pc_q;
    assign fetch.pc_valid = pc_valid_q;
    assign redirect       = redirect_q && ena;
    assign misalign       = misalign_q && ena;
    assign misalign_addr  = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen with a cycle-level behavioural reference model.
module tb_pc_gen;
    localparam int unsigned W = 64;
    localparam logic [W-1:0] RST_PC = 64'h8000_0000;

    logic         clk;
    logic         rst;
    logic         ena;
    logic         br_valid;
    logic [2:0]   br_type;
    logic         jump;
    logic         jalr;
    logic [W-1:0] ex_pc, imm, rs1, rs2, trap_vec, epc;
    logic         trap, mret;
    logic         redirect, misalign;
    logic [W-1:0] misalign_addr;

    int n_pass  = 0;
    int n_total = 0;

    pc_gen_if #(.CPU_WIDTH(W)) fetch ();

    pc_gen #(
        .CPU_WIDTH  (W),
        .RESET_PC   (RST_PC),
        .IALIGN_BITS(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .fetch        (fetch.master),
        .br_valid     (br_valid),
        .br_type      (br_type),
        .jump         (jump),
        .jalr         (jalr),
        .ex_pc        (ex_pc),
        .imm          (imm),
        .rs1          (rs1),
        .rs2          (rs2),
        .trap         (trap),
        .trap_vec     (trap_vec),
        .mret         (mret),
        .epc          (epc),
        .redirect     (redirect),
        .misalign     (misalign),
        .misalign_addr(misalign_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_pc, m_maddr;
    logic         m_valid, m_redir, m_mis, m_boot, m_halt;

    function automatic logic model_taken();
        logic c;
        if (!br_valid) return 1'b0;
        if (jump) return 1'b1;
        case (br_type)
            3'd1: c = rs1 == rs2;
            3'd2: c = rs1 != rs2;
            3'd3: c = $signed(rs1) < $signed(rs2);
            3'd4: c = !($signed(rs1) < $signed(rs2));
            3'd5: c = rs1 < rs2;
            3'd6: c = !(rs1 < rs2);
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    function automatic logic [W-1:0] model_target();
        logic [W-1:0] t;
        if (jump && jalr) begin
            t = rs1 + imm;
            t[0] = 1'b0;
        end else begin
            t = ex_pc + imm;
        end
        return t;
    endfunction

    // Advance the model on every edge, then compare all outputs shortly after
    always @(posedge clk) begin
        logic [W-1:0] tgt;
        if (rst) begin
            m_pc = RST_PC; m_valid = 0; m_redir = 0; m_mis = 0; m_maddr = '0;
            m_boot = 1; m_halt = 0;
        end else if (!ena) begin
            m_redir = 0; m_mis = 0;
        end else begin
            m_redir = 0; m_mis = 0;
            tgt = model_target();
            if (m_boot) begin
                m_boot = 0; m_valid = 1;
            end else if (trap) begin
                m_pc = trap_vec; m_redir = 1; m_halt = 0; m_valid = 1;
            end else if (!m_halt) begin
                if (mret) begin
                    m_pc = epc; m_redir = 1;
                end else if (model_taken()) begin
                    if (tgt % 4 == 0) begin
                        m_pc = tgt; m_redir = 1;
                    end else begin
                        m_mis = 1; m_maddr = tgt; m_halt = 1; m_valid = 0;
                    end
                end else if (fetch.if_ready) begin
                    m_pc = m_pc + 4;
                end
            end
        end
        #1;
        check("model_pc", fetch.pc, m_pc);
        check("model_pc_valid", W'(fetch.pc_valid), W'(m_valid));
        check("model_redirect", W'(redirect), W'(m_redir));
        check("model_misalign", W'(misalign), W'(m_mis));
        check("model_misalign_addr", misalign_addr, m_maddr);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        br_valid = 0; br_type = 3'd0; jump = 0; jalr = 0; trap = 0; mret = 0;
    endtask

    task automatic branch(input logic [2:0] t, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] pc_ex, input logic [W-1:0] im);
        br_valid = 1; br_type = t; rs1 = a; rs2 = b; ex_pc = pc_ex; imm = im;
    endtask

    initial begin
        rst = 1; ena = 1; fetch.if_ready = 1;
        idle();
        ex_pc = '0; imm = '0; rs1 = '0; rs2 = '0; trap_vec = '0; epc = '0;
        repeat (2) step();
        rst = 0;
        check("reset_pc", fetch.pc, 64'h8000_0000);
        check("reset_valid", W'(fetch.pc_valid), '0);
        check("reset_maddr", misalign_addr, '0);

        step(); check("run_pc0", fetch.pc, 64'h8000_0000);
        check("run_valid", W'(fetch.pc_valid), W'(1));
        step(); check("run_pc1", fetch.pc, 64'h8000_0004);
        step(); check("run_pc2", fetch.pc, 64'h8000_0008);

        // stall
        fetch.if_ready = 0;
        repeat (3) begin step(); check("stall_pc", fetch.pc, 64'h8000_0008); end
        fetch.if_ready = 1;
        step(); check("stall_release", fetch.pc, 64'h8000_000C);

        // signed vs unsigned compare
        branch(3'd3, '1, 64'd1, 64'h8000_0100, 64'h20);
        step(); check("blt_pc", fetch.pc, 64'h8000_0120);
        check("blt_redirect", W'(redirect), W'(1));
        idle();
        step(); check("blt_pulse_end", W'(redirect), '0);
        check("blt_seq", fetch.pc, 64'h8000_0124);
        branch(3'd5, '1, 64'd1, 64'h8000_0100, 64'h20);
        step(); check("bltu_pc", fetch.pc, 64'h8000_0128);
        check("bltu_noredir", W'(redirect), '0);
        idle();

        // jalr replacing a stalled pc
        fetch.if_ready = 0;
        step(); check("jalr_stall", fetch.pc, 64'h8000_0128);
        br_valid = 1; jump = 1; jalr = 1; rs1 = 64'h8000_0201; imm = '0;
        step(); check("jalr_pc", fetch.pc, 64'h8000_0200);
        check("jalr_redirect", W'(redirect), W'(1));
        idle();
        step(); check("jalr_hold", fetch.pc, 64'h8000_0200);
        fetch.if_ready = 1;

        // misaligned jal -> HALT
        br_valid = 1; jump = 1; jalr = 0; ex_pc = 64'h8000_0000; imm = 64'h6;
        step(); check("mis_pulse", W'(misalign), W'(1));
        check("mis_addr", misalign_addr, 64'h8000_0006);
        check("mis_valid", W'(fetch.pc_valid), '0);
        check("mis_noredir", W'(redirect), '0);
        idle();
        step(); check("mis_pulse_end", W'(misalign), '0);
        check("mis_addr_held", misalign_addr, 64'h8000_0006);
        branch(3'd1, 64'd5, 64'd5, 64'h8000_0000, 64'h40);
        step(); check("halt_ign_pc", fetch.pc, 64'h8000_0200);
        check("halt_ign_valid", W'(fetch.pc_valid), '0);
        idle();
        trap = 1; trap_vec = 64'h8000_1000;
        step(); check("trap_pc", fetch.pc, 64'h8000_1000);
        check("trap_valid", W'(fetch.pc_valid), W'(1));
        check("trap_redirect", W'(redirect), W'(1));
        idle();
        step(); check("trap_seq", fetch.pc, 64'h8000_1004);

        // trap beats a taken branch
        branch(3'd1, 64'd7, 64'd7, 64'h8000_0000, 64'h40);
        trap = 1; trap_vec = 64'h8000_2000;
        step(); check("prio_trap", fetch.pc, 64'h8000_2000);
        idle();

        // mret beats a taken branch
        branch(3'd2, 64'd1, 64'd2, 64'h8000_0000, 64'h40);
        mret = 1; epc = 64'h8000_3000;
        step(); check("mret_pc", fetch.pc, 64'h8000_3000);
        idle();

        // ena=0 freezes everything
        ena = 0; trap = 1; trap_vec = 64'h8000_4000;
        step(); check("ena_pc", fetch.pc, 64'h8000_3000);
        check("ena_noredir", W'(redirect), '0);
        step(); check("ena_pc2", fetch.pc, 64'h8000_3000);
        ena = 1; idle();
        step(); check("ena_resume", fetch.pc, 64'h8000_3004);

        // wrapping target, bge signed / bgeu unsigned
        br_valid = 1; jump = 1; ex_pc = 64'hFFFF_FFFF_FFFF_FFF0; imm = 64'h20;
        step(); check("wrap_pc", fetch.pc, 64'h10);
        idle();
        branch(3'd4, '1, 64'd1, 64'h8000_0000, 64'h80);
        step(); check("bge_nt", fetch.pc, 64'h14);
        branch(3'd6, '1, 64'd1, 64'h8000_0000, 64'h80);
        step(); check("bgeu_t", fetch.pc, 64'h8000_0080);
        branch(3'd7, 64'd1, 64'd1, 64'h8000_0000, 64'h40);
        step(); check("reserved_nt", fetch.pc, 64'h8000_0084);
        // jalr clears only bit0: bit1 set still misaligns
        idle(); br_valid = 1; jump = 1; jalr = 1; rs1 = 64'h8000_0203; imm = '0;
        step(); check("jalr_mis_addr", misalign_addr, 64'h8000_0202);
        check("jalr_mis_pulse", W'(misalign), W'(1));
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
